// File: rtl/sn74ls446_bus_seq_pkg.sv
// Shared types for the sn74ls446 A-side bus sequencer: FSM encoding, direction codes, counter load helper.
package sn74ls446_bus_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_SET = 3'd1,
        ST_WR_DRV = 3'd2,
        ST_WR_END = 3'd3,
        ST_TURN   = 3'd4,
        ST_RD_SET = 3'd5,
        ST_RD_EN  = 3'd6,
        ST_RD_END = 3'd7
    } seq_state_t;

    localparam logic [3:0] DIR_AB = 4'b1111;
    localparam logic [3:0] DIR_BA = 4'b0000;

    // A phase of N cycles loads N-1 and runs until the counter reads zero.
    function automatic logic [3:0] cnt_load(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/sn74ls446_bus_seq_cnt4.sv
// 4-bit loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Single-cycle update, no backpressure.
module seq_cnt4 (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/sn74ls446_bus_seq.sv
// A-side sequencer for one sn74ls446: turns write/read requests into gab/gba/dir sequences, break-before-make.
// Write busy 3+DRIVE_CYCLES, read busy 2+SAMPLE_CYCLES; requests while busy are dropped, not queued.
module sn74ls446_bus_seq
    import sn74ls446_bus_seq_pkg::*;
#(
    parameter int unsigned DRIVE_CYCLES  = 2,
    parameter int unsigned SAMPLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [3:0] wr_data,
    inout  wire  [3:0] a,
    output logic       gab,
    output logic       gba,
    output logic [3:0] dir,
    output logic [3:0] rd_data,
    output logic       ack,
    output logic       busy
);

    seq_state_t state_q, state_d;
    logic       gab_q, gab_d;
    logic       gba_q, gba_d;
    logic [3:0] dir_q, dir_d;
    logic [3:0] rd_data_q, rd_data_d;
    logic [3:0] a_out_q, a_out_d;
    logic       a_oe_q, a_oe_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       cnt_ld;
    logic [3:0] cnt_ld_val;
    logic       cnt_dec;
    logic       cnt_zero;

    seq_cnt4 u_cnt (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (cnt_ld),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        a_out_d    = a_out_q;
        rd_data_d  = rd_data_q;
        cnt_ld     = 1'b0;
        cnt_ld_val = 4'd0;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    state_d = ST_WR_SET;
                    a_out_d = ~wr_data;
                end else if (rd_req) begin
                    state_d = ST_RD_SET;
                end
            end
            ST_WR_SET: begin
                state_d    = ST_WR_DRV;
                cnt_ld     = 1'b1;
                cnt_ld_val = cnt_load(DRIVE_CYCLES);
            end
            ST_WR_DRV: begin
                cnt_dec = 1'b1;
                if (cnt_zero) state_d = ST_WR_END;
            end
            ST_WR_END: state_d = ST_TURN;
            ST_TURN:   state_d = ST_IDLE;
            ST_RD_SET: begin
                state_d    = ST_RD_EN;
                cnt_ld     = 1'b1;
                cnt_ld_val = cnt_load(SAMPLE_CYCLES);
            end
            ST_RD_EN: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    rd_data_d = ~a;
                    state_d   = ST_RD_END;
                end
            end
            ST_RD_END: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state they belong to.
    always_comb begin
        dir_d = dir_q;
        if (state_d == ST_WR_SET) dir_d = DIR_AB;
        if (state_d == ST_RD_SET) dir_d = DIR_BA;
        gab_d  = (state_d != ST_WR_DRV);
        gba_d  = (state_d != ST_RD_EN);
        a_oe_d = (state_d == ST_WR_SET) || (state_d == ST_WR_DRV) || (state_d == ST_WR_END);
        busy_d = (state_d != ST_IDLE);
        // ack lands on the first IDLE cycle, so both latencies count every busy cycle.
        ack_d  = (state_q == ST_TURN) || (state_q == ST_RD_END);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            gab_q     <= 1'b1;
            gba_q     <= 1'b1;
            dir_q     <= DIR_BA;
            rd_data_q <= 4'd0;
            a_out_q   <= 4'd0;
            a_oe_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gab_q     <= gab_d;
            gba_q     <= gba_d;
            dir_q     <= dir_d;
            rd_data_q <= rd_data_d;
            a_out_q   <= a_out_d;
            a_oe_q    <= a_oe_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign a       = a_oe_q ? a_out_q : 4'bzzzz;
    assign gab     = gab_q;
    assign gba     = gba_q;
    assign dir     = dir_q;
    assign rd_data = rd_data_q;
    assign ack     = ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sn74ls446_bus_seq.sv
// Bench for sn74ls446_bus_seq: three instances (N=2, 1, 15) share stimulus; a scoreboard checks each ack.
module tb_sn74ls446_bus_seq;

    localparam int N_INST = 3;

    typedef struct {
        bit         is_wr;
        logic [3:0] data;
        int         exp_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] b_val = 4'd0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    wire [N_INST-1:0]      gab_v, gba_v, ack_v, busy_v;
    wire [N_INST-1:0][3:0] dir_v, rd_v, a_v;

    exp_t exp_q[N_INST][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < N_INST; k++) begin : g
        localparam int unsigned N = (k == 0) ? 2 : (k == 1) ? 1 : 15;
        wire [3:0] a;

        pullup (a[0]);
        pullup (a[1]);
        pullup (a[2]);
        pullup (a[3]);

        // Transceiver B->A path: with gba low the chip drives A with the inverted B bus.
        assign a = !gba_v[k] ? ~b_val : 4'bzzzz;
        assign a_v[k] = a;

        sn74ls446_bus_seq #(.DRIVE_CYCLES(N), .SAMPLE_CYCLES(N)) u_dut (
            .clk     (clk),
            .clr_n   (clr_n),
            .wr_req  (wr_req),
            .rd_req  (rd_req),
            .wr_data (wr_data),
            .a       (a),
            .gab     (gab_v[k]),
            .gba     (gba_v[k]),
            .dir     (dir_v[k]),
            .rd_data (rd_v[k]),
            .ack     (ack_v[k]),
            .busy    (busy_v[k])
        );

        always @(negedge clk) begin
            if (clr_n && !gba_v[k] && u_dut.a_oe_q) begin
                n_fail++;
                $display("FAIL a_contention inst%0d: A driven while gba low (cycle %0d)", k, cyc);
            end
        end
    end

    int         gab_run[N_INST];
    int         gba_run[N_INST];
    int         gab_len[N_INST];
    int         gba_len[N_INST];
    logic [3:0] bbus_seen[N_INST];

    initial begin
        for (int k = 0; k < N_INST; k++) begin
            gab_run[k] = 0; gba_run[k] = 0; gab_len[k] = 0; gba_len[k] = 0; bbus_seen[k] = 4'd0;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (clr_n) begin
            for (int k = 0; k < N_INST; k++) begin
                if (!gab_v[k]) begin
                    gab_run[k]++;
                    bbus_seen[k] = ~a_v[k];
                end else if (gab_run[k] != 0) begin
                    gab_len[k] = gab_run[k];
                    gab_run[k] = 0;
                end
                if (!gba_v[k]) begin
                    gba_run[k]++;
                end else if (gba_run[k] != 0) begin
                    gba_len[k] = gba_run[k];
                    gba_run[k] = 0;
                end
                if (!gab_v[k] && !gba_v[k]) begin
                    n_fail++;
                    $display("FAIL both_enables inst%0d: gab and gba low together (cycle %0d)", k, cyc);
                end
                if (ack_v[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("spurious_ack", k, 32'(ack_v[k]), 32'd0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk("ack_latency", k, cyc, e.exp_cyc);
                        chk("busy_at_ack", k, 32'(busy_v[k]), 32'd0);
                        chk("a_released", k, 32'(a_v[k]), 32'hf);
                        if (e.is_wr) begin
                            chk("gab_low_len", k, gab_len[k], n_of(k));
                            chk("bbus_write", k, 32'(bbus_seen[k]), 32'(e.data));
                            chk("dir_after_wr", k, 32'(dir_v[k]), 32'hf);
                        end else begin
                            chk("gba_low_len", k, gba_len[k], n_of(k));
                            chk("rd_data", k, 32'(rd_v[k]), 32'(e.data));
                            chk("dir_after_rd", k, 32'(dir_v[k]), 32'h0);
                        end
                    end
                end
            end
        end
    end

    function automatic bit all_idle();
        for (int k = 0; k < N_INST; k++) begin
            if (exp_q[k].size() != 0 || busy_v[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (n < 200 && !all_idle()) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: transactions still outstanding at cycle %0d", cyc);
        end
    endtask

    // Reference: a write shows d on B for N cycles and acks after 3+N; a read returns B after 2+N; write wins.
    task automatic issue(input bit w, input bit r, input logic [3:0] d, input logic [3:0] b, input int hold);
        exp_t       e;
        logic [3:0] nd;
        nd = ~d;
        @(negedge clk);
        wr_req  = w;
        rd_req  = r;
        wr_data = d;
        b_val   = b;
        for (int k = 0; k < N_INST; k++) begin
            e.is_wr   = w;
            e.data    = w ? d : b;
            e.exp_cyc = cyc + 1 + (w ? 3 + n_of(k) : 2 + n_of(k));
            exp_q[k].push_back(e);
        end
        @(negedge clk);
        wr_data = 4'($urandom);
        for (int k = 0; k < N_INST; k++) begin
            if (w) begin
                chk("a_wr_set", k, 32'(a_v[k]), 32'(nd));
                chk("dir_wr_set", k, 32'(dir_v[k]), 32'hf);
            end else begin
                chk("dir_rd_set", k, 32'(dir_v[k]), 32'h0);
            end
        end
        repeat (hold) @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        int sel;
        int n;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N_INST; k++) begin
            chk("rst_gab", k, 32'(gab_v[k]), 32'd1);
            chk("rst_gba", k, 32'(gba_v[k]), 32'd1);
            chk("rst_dir", k, 32'(dir_v[k]), 32'd0);
            chk("rst_a", k, 32'(a_v[k]), 32'hf);
            chk("rst_rd_data", k, 32'(rd_v[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
            chk("rst_ack", k, 32'(ack_v[k]), 32'd0);
        end
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_INST; k++) chk("idle_after_rst", k, 32'(busy_v[k]), 32'd0);

        issue(1'b1, 1'b0, 4'b1010, 4'b0000, 0);
        wait_idle();
        issue(1'b0, 1'b1, 4'b0000, 4'b1100, 0);
        wait_idle();
        issue(1'b1, 1'b1, 4'b0011, 4'b0101, 2);
        wait_idle();

        issue(1'b1, 1'b0, 4'b0110, 4'b0000, 0);
        n = 0;
        while (gab_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr_drv", 0, 32'(gab_v[0]), 32'd0);
        #2 clr_n = 1'b0;
        #1;
        for (int k = 0; k < N_INST; k++) begin
            chk("abort_gab", k, 32'(gab_v[k]), 32'd1);
            chk("abort_a", k, 32'(a_v[k]), 32'hf);
            chk("abort_busy", k, 32'(busy_v[k]), 32'd0);
            exp_q[k].delete();
        end
        #1 clr_n = 1'b1;
        wait_idle();
        issue(1'b1, 1'b0, 4'b1001, 4'b0000, 0);
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 2);
            issue(sel != 1, sel != 0, 4'($urandom), 4'($urandom), $urandom_range(0, 2));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
